// File: rtl/hub_pkg.sv
// Shared hub-bus definitions: address width, long byte-enable mask,
// block-mover state encoding and mode constants.
package hub_pkg;

    localparam int         HUB_A_W     = 14;
    localparam logic [3:0] HUB_WB_LONG = 4'hF;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RD   = 2'd1,
        CAP  = 2'd2,
        WR   = 2'd3
    } hub_mv_state_t;

    localparam logic HUB_MV_COPY = 1'b0;
    localparam logic HUB_MV_FILL = 1'b1;

endpackage

// File: rtl/hub_mover.sv
// Hub block-transfer initiator: copies or fills a run of longs through this
// block's hub slot, two slots per long for copy and one per long for fill.
module hub_mover
    import hub_pkg::*;
#(
    parameter int CNT_W = 14
) (
    input  logic               clk_cog,
    input  logic               nres,
    input  logic               ena_bus,
    input  logic               start,
    input  logic               mode,
    input  logic [HUB_A_W-1:0] src,
    input  logic [HUB_A_W-1:0] dst,
    input  logic [CNT_W-1:0]   cnt,
    input  logic [31:0]        fill_d,
    output logic               busy,
    output logic               done,
    output logic               bus_w,
    output logic [3:0]         bus_wb,
    output logic [HUB_A_W-1:0] bus_a,
    output logic [31:0]        bus_d,
    input  logic [31:0]        bus_q
);

    hub_mv_state_t      state;
    logic [HUB_A_W-1:0] sp;
    logic [HUB_A_W-1:0] dp;
    logic [CNT_W-1:0]   rem;
    logic               md;
    logic [31:0]        hold;

    // hold is the write-data register: the captured read long for copy, the
    // fill pattern for fill, and zero whenever the block is idle.
    assign bus_d = hold;

    always_ff @(posedge clk_cog or negedge nres) begin
        if (!nres) begin
            state  <= IDLE;
            sp     <= '0;
            dp     <= '0;
            rem    <= '0;
            md     <= HUB_MV_COPY;
            hold   <= '0;
            busy   <= 1'b0;
            done   <= 1'b0;
            bus_w  <= 1'b0;
            bus_wb <= '0;
            bus_a  <= '0;
        end else begin
            done <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (start) begin
                        sp  <= src;
                        dp  <= dst;
                        rem <= cnt;
                        md  <= mode;
                        if (cnt == '0) begin
                            done <= 1'b1;
                        end else begin
                            busy <= 1'b1;
                            if (mode == HUB_MV_FILL) begin
                                state  <= WR;
                                hold   <= fill_d;
                                bus_a  <= dst;
                                bus_w  <= 1'b1;
                                bus_wb <= HUB_WB_LONG;
                            end else begin
                                state <= RD;
                                bus_a <= src;
                            end
                        end
                    end
                end
                RD: begin
                    if (ena_bus) begin
                        state <= CAP;
                    end
                end
                CAP: begin
                    // Read data is valid now, one cycle after the read slot.
                    hold   <= bus_q;
                    state  <= WR;
                    bus_a  <= dp;
                    bus_w  <= 1'b1;
                    bus_wb <= HUB_WB_LONG;
                end
                WR: begin
                    if (ena_bus) begin
                        sp  <= sp + HUB_A_W'(1);
                        dp  <= dp + HUB_A_W'(1);
                        rem <= rem - CNT_W'(1);
                        if (rem == CNT_W'(1)) begin
                            state  <= IDLE;
                            busy   <= 1'b0;
                            done   <= 1'b1;
                            hold   <= '0;
                            bus_a  <= '0;
                            bus_w  <= 1'b0;
                            bus_wb <= '0;
                        end else if (md == HUB_MV_FILL) begin
                            bus_a <= dp + HUB_A_W'(1);
                        end else begin
                            state  <= RD;
                            bus_a  <= sp + HUB_A_W'(1);
                            bus_w  <= 1'b0;
                            bus_wb <= '0;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_hub_mover.sv
// Self-checking bench for hub_mover: hub memory responder, directed scenarios
// and randomized transfers checked against a whole-memory reference model.
module tb_hub_mover;
    import hub_pkg::*;

    localparam int CNT_W = 14;

    logic               clk_cog = 1'b0;
    logic               nres    = 1'b0;
    logic               ena_bus = 1'b0;
    logic               start   = 1'b0;
    logic               mode    = 1'b0;
    logic [HUB_A_W-1:0] src     = '0;
    logic [HUB_A_W-1:0] dst     = '0;
    logic [CNT_W-1:0]   cnt     = '0;
    logic [31:0]        fill_d  = '0;
    logic               busy;
    logic               done;
    logic               bus_w;
    logic [3:0]         bus_wb;
    logic [HUB_A_W-1:0] bus_a;
    logic [31:0]        bus_d;
    logic [31:0]        bus_q   = '0;

    hub_mover #(.CNT_W(CNT_W)) dut (
        .clk_cog (clk_cog),
        .nres    (nres),
        .ena_bus (ena_bus),
        .start   (start),
        .mode    (mode),
        .src     (src),
        .dst     (dst),
        .cnt     (cnt),
        .fill_d  (fill_d),
        .busy    (busy),
        .done    (done),
        .bus_w   (bus_w),
        .bus_wb  (bus_wb),
        .bus_a   (bus_a),
        .bus_d   (bus_d),
        .bus_q   (bus_q)
    );

    always #5 clk_cog = ~clk_cog;

    logic [31:0]        mem     [0:16383];
    logic [31:0]        exp_mem [0:16383];
    int                 checks = 0;
    int                 errors = 0;
    int                 ena_period = 16;
    int                 cyc = 0;
    logic               slot_w [$];
    logic [HUB_A_W-1:0] wr_addr [$];
    int                 done_cnt = 0;
    int                 both_cnt = 0;
    int                 stray_cnt = 0;
    int                 busy_cnt = 0;

    // RAM below $2000, ROM above; the first three longs hold 1, 2, 3.
    function automatic logic [31:0] initVal(int i);
        if (i < 3) return 32'(i + 1);
        if (i >= 8192) return 32'hC0DE0000 | 32'(i);
        return 32'h5A5A0000 ^ 32'(i * 40503);
    endfunction

    // Hub memory responder: samples on slot edges, ROM ignores writes.
    initial begin
        for (int i = 0; i < 16384; i++) mem[i] = initVal(i);
        forever begin
            @(posedge clk_cog);
            if (ena_bus) begin
                bus_q <= mem[bus_a];
                if (bus_w && !bus_a[13]) begin
                    for (int b = 0; b < 4; b++)
                        if (bus_wb[b]) mem[bus_a][8*b +: 8] <= bus_d[8*b +: 8];
                end
            end
        end
    end

    // Slot generator and bus monitor, both on the inactive edge.
    initial begin
        forever begin
            @(negedge clk_cog);
            cyc++;
            if (ena_period == 0) ena_bus = ($urandom_range(0, 1) == 1);
            else ena_bus = ((cyc % ena_period) == 0);
            if (ena_bus && busy) begin
                slot_w.push_back(bus_w);
                if (bus_w) wr_addr.push_back(bus_a);
            end
            if (done) done_cnt++;
            if (done && busy) both_cnt++;
            if (bus_w && !busy) stray_cnt++;
            if (busy) busy_cnt++;
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("[TB] FAIL %s got %h expected %h", tag, got, want);
        end
    endtask

    task automatic clearMon();
        slot_w.delete();
        wr_addr.delete();
        done_cnt  = 0;
        both_cnt  = 0;
        stray_cnt = 0;
        busy_cnt  = 0;
    endtask

    // Reference: long i of the run goes to dst+i, taking the fill pattern or
    // whatever src+i holds at that moment; ROM addresses keep their contents.
    task automatic modelCmd(input logic m, input logic [13:0] s, input logic [13:0] d,
                            input int n, input logic [31:0] f);
        logic [13:0] a;
        logic [13:0] r;
        for (int i = 0; i < n; i++) begin
            a = d + 14'(i);
            r = s + 14'(i);
            if (!a[13]) exp_mem[a] = m ? f : exp_mem[r];
        end
    endtask

    task automatic applyStimulus(input logic m, input logic [13:0] s, input logic [13:0] d,
                                 input int n, input logic [31:0] f);
        clearMon();
        @(negedge clk_cog);
        #1;
        start  = 1'b1;
        mode   = m;
        src    = s;
        dst    = d;
        cnt    = CNT_W'(n);
        fill_d = f;
        @(negedge clk_cog);
        #1;
        start = 1'b0;
    endtask

    task automatic waitDone(input string tag, input int limit);
        int k = 0;
        while (done_cnt == 0 && k < limit) begin
            @(negedge clk_cog);
            #1;
            k++;
        end
        if (done_cnt == 0) checkOutput({tag, "_timeout"}, 32'd0, 32'd1);
        repeat (2) @(negedge clk_cog);
        #1;
    endtask

    task automatic checkMem(input string tag);
        int bad = 0;
        for (int i = 0; i < 16384; i++)
            if (mem[i] !== exp_mem[i]) bad++;
        checkOutput(tag, 32'(bad), 32'd0);
    endtask

    initial begin
        logic [31:0]        pat;
        logic [HUB_A_W-1:0] wrap_a [3];
        logic               m;
        logic [13:0]        s;
        logic [13:0]        d;
        int                 n;
        logic [31:0]        f;
        int                 k;

        for (int i = 0; i < 16384; i++) exp_mem[i] = initVal(i);
        wrap_a[0] = 14'h3FFE;
        wrap_a[1] = 14'h3FFF;
        wrap_a[2] = 14'h0000;

        repeat (3) @(negedge clk_cog);
        #1;
        checkOutput("rst_ctl", 32'({busy, done, bus_w, bus_wb}), 32'd0);
        checkOutput("rst_a", 32'(bus_a), 32'd0);
        checkOutput("rst_d", bus_d, 32'd0);
        nres = 1'b1;

        // Fill four longs with slots every 16 clocks.
        ena_period = 16;
        modelCmd(HUB_MV_FILL, 14'h0, 14'h0100, 4, 32'hDEADBEEF);
        applyStimulus(HUB_MV_FILL, 14'h0, 14'h0100, 4, 32'hDEADBEEF);
        checkOutput("fill_first", 32'({busy, bus_w, bus_wb, bus_a}),
                    32'({1'b1, 1'b1, 4'hF, 14'h0100}));
        checkOutput("fill_data", bus_d, 32'hDEADBEEF);
        waitDone("fill", 2000);
        checkOutput("fill_slots", 32'(slot_w.size()), 32'd4);
        checkOutput("fill_writes", 32'(wr_addr.size()), 32'd4);
        checkOutput("fill_done_cnt", 32'(done_cnt), 32'd1);
        checkOutput("fill_done_busy", 32'(both_cnt + stray_cnt), 32'd0);
        checkMem("fill_mem");

        // Copy three longs: reads and writes must alternate.
        modelCmd(HUB_MV_COPY, 14'h0000, 14'h0200, 3, 32'h0);
        applyStimulus(HUB_MV_COPY, 14'h0000, 14'h0200, 3, 32'h0);
        waitDone("copy", 2000);
        pat = '0;
        foreach (slot_w[i]) pat = {pat[30:0], slot_w[i]};
        checkOutput("copy_slots", 32'(slot_w.size()), 32'd6);
        checkOutput("copy_pattern", pat, 32'b010101);
        checkOutput("copy_done_cnt", 32'(done_cnt), 32'd1);
        checkOutput("copy_word2", mem[14'h0202], 32'd3);
        checkMem("copy_mem");

        // Zero count completes immediately without ever going busy.
        applyStimulus(HUB_MV_COPY, 14'h0010, 14'h0020, 0, 32'h0);
        checkOutput("zero_done", 32'(done), 32'd1);
        checkOutput("zero_busy", 32'(busy), 32'd0);
        repeat (4) @(negedge clk_cog);
        #1;
        checkOutput("zero_done_cnt", 32'(done_cnt), 32'd1);
        checkOutput("zero_activity", 32'(busy_cnt + stray_cnt + wr_addr.size()), 32'd0);

        // Fill across the top of the address space.
        modelCmd(HUB_MV_FILL, 14'h0, 14'h3FFE, 3, 32'h12345678);
        applyStimulus(HUB_MV_FILL, 14'h0, 14'h3FFE, 3, 32'h12345678);
        waitDone("wrap", 2000);
        checkOutput("wrap_writes", 32'(wr_addr.size()), 32'd3);
        for (int i = 0; i < 3; i++)
            checkOutput("wrap_addr", (i < wr_addr.size()) ? 32'(wr_addr[i]) : 32'hFFFFFFFF,
                        32'(wrap_a[i]));
        checkMem("wrap_mem");

        // Copy from ROM into RAM.
        modelCmd(HUB_MV_COPY, 14'h2000, 14'h0300, 1, 32'h0);
        applyStimulus(HUB_MV_COPY, 14'h2000, 14'h0300, 1, 32'h0);
        waitDone("rom", 2000);
        checkOutput("rom_src", mem[14'h0300], initVal(14'h2000));
        checkMem("rom_mem");

        // Ignored second command, then reset after the first long is written.
        modelCmd(HUB_MV_COPY, 14'h0010, 14'h0400, 1, 32'h0);
        applyStimulus(HUB_MV_COPY, 14'h0010, 14'h0400, 8, 32'h0);
        repeat (2) @(negedge clk_cog);
        #1;
        start  = 1'b1;
        mode   = HUB_MV_FILL;
        dst    = 14'h0500;
        cnt    = CNT_W'(2);
        fill_d = 32'hFEEDF00D;
        @(negedge clk_cog);
        #1;
        start = 1'b0;
        k = 0;
        while (slot_w.size() < 2 && k < 200) begin
            @(negedge clk_cog);
            #1;
            k++;
        end
        checkOutput("dist_slots_seen", 32'(slot_w.size()), 32'd2);
        @(posedge clk_cog);
        #2;
        nres = 1'b0;
        #1;
        checkOutput("dist_rst_ctl", 32'({busy, done, bus_w, bus_wb}), 32'd0);
        checkOutput("dist_rst_a", 32'(bus_a), 32'd0);
        checkOutput("dist_rst_d", bus_d, 32'd0);
        repeat (3) @(negedge clk_cog);
        #1;
        nres = 1'b1;
        repeat (40) @(negedge clk_cog);
        #1;
        checkOutput("dist_done_cnt", 32'(done_cnt), 32'd0);
        checkOutput("dist_writes", 32'(wr_addr.size()), 32'd1);
        checkMem("dist_mem");

        // Randomized transfers with random slot timing.
        ena_period = 0;
        for (int t = 0; t < 30; t++) begin
            m = 1'($urandom_range(0, 1));
            s = 14'($urandom);
            d = 14'($urandom);
            n = $urandom_range(0, 12);
            f = $urandom;
            modelCmd(m, s, d, n, f);
            applyStimulus(m, s, d, n, f);
            waitDone("rnd", 1000);
            checkOutput("rnd_done_cnt", 32'(done_cnt), 32'd1);
            checkOutput("rnd_writes", 32'(wr_addr.size()), 32'(n));
            checkOutput("rnd_done_busy", 32'(both_cnt + stray_cnt), 32'd0);
            checkMem("rnd_mem");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
